// File: rtl/pdatapath_pkg.sv
// Shared definitions for the multicycle processor datapath: opcodes,
// instruction field positions, FSM state type and small decode helpers.
package pdatapath_pkg;

  localparam int INSTR_W = 16;

  // Instruction field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 10;
  localparam int RT_HI  = 9;
  localparam int RT_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcodes; 13 and 14 fall through decode as NOP
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LI   = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_J    = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  // R-type ops occupy opcodes 0..5 and write rd
  function automatic logic is_rtype(input logic [3:0] op);
    return (op <= OP_SLT);
  endfunction

  // Ops whose result comes straight from the ALU and go through WB
  function automatic logic is_alu_wb(input logic [3:0] op);
    return (op <= OP_LI);
  endfunction

  // Ops that refresh the overflow flag
  function automatic logic updates_ovf(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/pdp_regfile.sv
// 4-entry register file: two asynchronous read ports for operands, one
// synchronous write port, plus a combinational debug tap. r0 reads zero.
module pdp_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        raddr_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [4];

  // Register storage; writes aimed at r0 are dropped so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we && (waddr != 2'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a == 2'd0) ? '0 : regs[raddr_a];
  assign rdata_b  = (raddr_b == 2'd0) ? '0 : regs[raddr_b];
  assign dbg_data = (dbg_sel == 2'd0) ? '0 : regs[dbg_sel];

endmodule

// File: rtl/pdatapath_multicycle.sv
// Multicycle 16-bit-instruction processor: IDLE -> FETCH -> DECODE -> EXEC
// [-> MEM] [-> WB] -> IDLE, one instruction per start. Instruction and data
// memories are inline and are not cleared by reset.
//
// Strobe semantics: step and prog_we are single-cycle strobes sampled on the
// rising clock edge. A start (run_mode=1, or step=1 in step mode) is taken
// only in IDLE. prog_we is taken only in IDLE or HALT; when it coincides
// with a start in IDLE the write wins and the start waits one cycle, so a
// step pulse in that cycle is dropped.
module pdatapath_multicycle
  import pdatapath_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int IMEM_DEPTH = 16,
  parameter  int DMEM_DEPTH = 16,
  localparam int PW         = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_general,
  input  logic               run_mode,
  input  logic               step,
  input  logic               prog_we,
  input  logic [PW-1:0]      prog_addr,
  input  logic [15:0]        prog_data,
  input  logic [1:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [PW-1:0]      pc,
  output logic [DATA_W-1:0]  result,
  output logic               ovf,
  output logic               busy,
  output logic               halted,
  output logic               instr_done
);

  localparam int AW = $clog2(DMEM_DEPTH);

  // FSM state (kept as a named enum so it can be observed directly)
  state_t state_q, state_d;

  // Memories
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  dmem [DMEM_DEPTH];

  // Pipeline-style holding registers between multicycle stages
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0]  a_q, b_q, alu_q, mdr_q, result_q;
  logic               alu_ovf_q, ovf_q, instr_done_q;
  logic [PW-1:0]      pc_q, pc_next;

  // Decoded fields
  logic [3:0]        op;
  logic [1:0]        rs_f, rt_f, rd_f;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] imm_ext;
  logic [PW-1:0]     imm_pc;

  assign op      = ir_q[OPC_HI:OPC_LO];
  assign rs_f    = ir_q[RS_HI:RS_LO];
  assign rt_f    = ir_q[RT_HI:RT_LO];
  assign rd_f    = ir_q[RD_HI:RD_LO];
  assign imm8    = ir_q[IMM_HI:IMM_LO];
  assign imm_ext = DATA_W'($signed(imm8));
  assign imm_pc  = PW'($signed(imm8));

  // Control
  logic              start, busy_w, retire, imem_we, dmem_we;
  logic [AW-1:0]     daddr;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  // Register file interface
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [1:0]        rf_waddr;
  logic              rf_we;

  assign start   = (run_mode | step) & ~prog_we;
  assign imem_we = prog_we & ((state_q == ST_IDLE) | (state_q == ST_HALT));
  assign dmem_we = (state_q == ST_MEM) && (op == OP_SW);
  assign daddr   = AW'(alu_q);

  assign rf_we    = (state_q == ST_WB);
  assign rf_waddr = is_rtype(op) ? rd_f : rt_f;
  assign rf_wdata = (op == OP_LW) ? mdr_q : alu_q;

  pdp_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_general),
    .raddr_a  (rs_f),
    .raddr_b  (rt_f),
    .rdata_a  (rf_rdata_a),
    .rdata_b  (rf_rdata_b),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_general) begin
    if (!rst_general) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // FSM next state, busy and retirement decode
  always_comb begin
    state_d = state_q;
    busy_w  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = (op == OP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (is_alu_wb(op))                      state_d = ST_WB;
        else if ((op == OP_LW) || (op == OP_SW)) state_d = ST_MEM;
        else                                     state_d = ST_IDLE;
      end
      ST_MEM:    state_d = (op == OP_LW) ? ST_WB : ST_IDLE;
      ST_WB:     state_d = ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
    busy_w = (state_q != ST_IDLE) && (state_q != ST_HALT);
    // Only EXEC, MEM and WB can fall back to IDLE, each ending an instruction
    retire = busy_w && (state_d == ST_IDLE);
  end

  // ALU, evaluated on the operands latched in DECODE
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = a_q + b_q;
        alu_ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLT:  alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
      OP_ADDI: begin
        alu_res = a_q + imm_ext;
        alu_ovf = (a_q[DATA_W-1] == imm_ext[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_LI:   alu_res = imm_ext;
      OP_LW,
      OP_SW:   alu_res = a_q + imm_ext;   // effective data address
      default: alu_res = '0;
    endcase
  end

  // Next PC: sequential by default, branch/jump resolved in EXEC; wraps naturally
  always_comb begin
    pc_next = pc_q + PW'(1);
    if (state_q == ST_EXEC) begin
      case (op)
        OP_BEQ:  if (a_q == b_q) pc_next = pc_q + PW'(1) + imm_pc;
        OP_BNE:  if (a_q != b_q) pc_next = pc_q + PW'(1) + imm_pc;
        OP_J:    pc_next = PW'(imm8);
        default: pc_next = pc_q + PW'(1);
      endcase
    end
  end

  // Datapath registers, PC, result/overflow and retirement pulse
  always_ff @(posedge clk or negedge rst_general) begin
    if (!rst_general) begin
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_q        <= '0;
      alu_ovf_q    <= 1'b0;
      mdr_q        <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      pc_q         <= '0;
      instr_done_q <= 1'b0;
    end else begin
      instr_done_q <= retire;
      if (state_q == ST_FETCH) ir_q <= imem[pc_q];
      if (state_q == ST_DECODE) begin
        a_q <= rf_rdata_a;
        b_q <= rf_rdata_b;
      end
      if (state_q == ST_EXEC) begin
        alu_q     <= alu_res;
        alu_ovf_q <= alu_ovf;
      end
      if ((state_q == ST_MEM) && (op == OP_LW)) mdr_q <= dmem[daddr];
      if (rf_we) begin
        result_q <= rf_wdata;
        if (updates_ovf(op)) ovf_q <= alu_ovf_q;
      end
      if (retire) pc_q <= pc_next;
    end
  end

  // Instruction memory programming port (contents survive reset)
  always_ff @(posedge clk) begin
    if (imem_we) imem[prog_addr] <= prog_data;
  end

  // Data memory store port (contents survive reset)
  always_ff @(posedge clk) begin
    if (dmem_we) dmem[daddr] <= b_q;
  end

  assign pc         = pc_q;
  assign result     = result_q;
  assign ovf        = ovf_q;
  assign busy       = busy_w;
  assign halted     = (state_q == ST_HALT);
  assign instr_done = instr_done_q;

endmodule

// File: tb/tb_pdatapath_multicycle.sv
// Directed bench for pdatapath_multicycle: per-instruction expectations of
// {pc, result} are queued when an instruction is launched and compared when
// instr_done pulses; architectural state is checked at key points.
module tb_pdatapath_multicycle;

  localparam int DATA_W = 8;
  localparam int PW     = 4;
  localparam int SB_W   = PW + DATA_W;

  localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_AND = 4'd2, T_SLT = 4'd5;
  localparam logic [3:0] T_ADDI = 4'd6, T_LI = 4'd7, T_LW = 4'd8, T_SW = 4'd9;
  localparam logic [3:0] T_BEQ = 4'd10, T_BNE = 4'd11, T_J = 4'd12;
  localparam logic [15:0] I_NOP  = 16'hD000;
  localparam logic [15:0] I_HALT = 16'hF000;

  // Clock / reset / DUT signals
  logic              clk;
  logic              rst_general;
  logic              run_mode;
  logic              step;
  logic              prog_we;
  logic [PW-1:0]     prog_addr;
  logic [15:0]       prog_data;
  logic [1:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic [PW-1:0]     pc;
  logic [DATA_W-1:0] result;
  logic              ovf;
  logic              busy;
  logic              halted;
  logic              instr_done;

  int checks   = 0;
  int failures = 0;
  logic [SB_W-1:0] exp_q[$];

  logic [7:0] b_res [7];
  logic       b_ovf [7];
  int         t;

  pdatapath_multicycle dut (
    .clk         (clk),
    .rst_general (rst_general),
    .run_mode    (run_mode),
    .step        (step),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .pc          (pc),
    .result      (result),
    .ovf         (ovf),
    .busy        (busy),
    .halted      (halted),
    .instr_done  (instr_done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a wedged run
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [1:0] rs,
                                        input logic [1:0] rt, input logic [1:0] rd);
    return {op, rs, rt, rd, 6'b0};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [1:0] rs,
                                        input logic [1:0] rt, input logic [7:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_general = 1'b0;
    run_mode    = 1'b0;
    step        = 1'b0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    dbg_sel     = 2'd0;
    tick();
    tick();
    rst_general = 1'b1;
    tick();
  endtask

  task automatic load(input logic [PW-1:0] addr, input logic [15:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  // Wait (bounded) for instr_done, then pop and compare the scoreboard head
  task automatic wait_retire(input string tag, output int ticks);
    logic [SB_W-1:0] exp_v;
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while ((instr_done !== 1'b1) && (ticks < 40));
    checks++;
    assert (instr_done === 1'b1) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=1", tag, instr_done);
    end
    if (instr_done === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL %s_sb_empty observed=0 expected=nonzero", tag);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        check(tag, 16'({pc, result}), 16'(exp_v));
      end
    end
  endtask

  task automatic step_instr(input string tag, input logic [PW-1:0] exp_pc,
                            input logic [DATA_W-1:0] exp_res, input int exp_ticks);
    int n;
    exp_q.push_back({exp_pc, exp_res});
    pulse_step();
    wait_retire(tag, n);
    check({tag, "_lat"}, 16'(n), 16'(exp_ticks));
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while ((halted !== 1'b1) && (n < 40)) begin
      tick();
      n++;
    end
    check(tag, 16'(halted), 16'(1));
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [DATA_W-1:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, 16'(dbg_data), 16'(exp));
  endtask

  initial begin
    // ---------------- reset state ----------------
    apply_reset();
    check("rst_pc", 16'(pc), 16'(0));
    check("rst_result", 16'(result), 16'(0));
    check("rst_ovf", 16'(ovf), 16'(0));
    check("rst_busy", 16'(busy), 16'(0));
    check("rst_halted", 16'(halted), 16'(0));
    check("rst_done", 16'(instr_done), 16'(0));
    for (int r = 0; r < 4; r++) check_reg("rst_reg", 2'(r), 8'h00);

    // ---------------- step mode: LI, LI, ADD, HALT ----------------
    load(4'd0, enc_i(T_LI, 2'd0, 2'd1, 8'd5));
    load(4'd1, enc_i(T_LI, 2'd0, 2'd2, 8'd3));
    load(4'd2, enc_r(T_ADD, 2'd1, 2'd2, 2'd3));
    load(4'd3, I_HALT);
    tick(); tick(); tick();
    check("a_idle_hold", 16'(busy), 16'(0));
    step_instr("a_li1", 4'd1, 8'd5, 4);
    step_instr("a_li2", 4'd2, 8'd3, 4);
    step_instr("a_add", 4'd3, 8'd8, 4);
    pulse_step();
    wait_halt("a_halt");
    check_reg("a_r3", 2'd3, 8'd8);
    check("a_result", 16'(result), 16'(8));
    check("a_pc", 16'(pc), 16'(3));
    check("a_busy_halt", 16'(busy), 16'(0));
    run_mode = 1'b1;
    pulse_step();
    tick(); tick(); tick(); tick();
    check("a_halt_sticky", 16'(halted), 16'(1));
    check("a_halt_pc", 16'(pc), 16'(3));
    run_mode = 1'b0;

    // ---------------- overflow behaviour ----------------
    apply_reset();
    load(4'd0, enc_i(T_LI, 2'd0, 2'd1, 8'h7F));
    load(4'd1, enc_i(T_ADDI, 2'd1, 2'd1, 8'h01));
    load(4'd2, enc_r(T_AND, 2'd1, 2'd1, 2'd2));
    load(4'd3, enc_r(T_SLT, 2'd1, 2'd0, 2'd3));
    load(4'd4, enc_r(T_ADD, 2'd0, 2'd0, 2'd3));
    load(4'd5, enc_i(T_LI, 2'd0, 2'd2, 8'h01));
    load(4'd6, enc_r(T_SUB, 2'd1, 2'd2, 2'd2));
    load(4'd7, I_HALT);
    b_res = '{8'h7F, 8'h80, 8'h80, 8'h01, 8'h00, 8'h01, 8'h7F};
    b_ovf = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      step_instr("b_step", 4'(i + 1), b_res[i], 4);
      check("b_ovf", 16'(ovf), 16'(b_ovf[i]));
    end
    check_reg("b_r1", 2'd1, 8'h80);
    check_reg("b_r2", 2'd2, 8'h7F);
    check_reg("b_r3", 2'd3, 8'h00);

    // ---------------- run mode store/load ----------------
    apply_reset();
    load(4'd0, enc_i(T_LI, 2'd0, 2'd1, 8'h5A));
    load(4'd1, enc_i(T_SW, 2'd0, 2'd1, 8'd15));
    load(4'd2, enc_i(T_LW, 2'd0, 2'd2, 8'd15));
    load(4'd3, I_HALT);
    exp_q.push_back({4'd1, 8'h5A});
    exp_q.push_back({4'd2, 8'h5A});
    exp_q.push_back({4'd3, 8'h5A});
    run_mode = 1'b1;
    wait_retire("c_li", t);
    check("c_li_lat", 16'(t), 16'(5));
    wait_retire("c_sw", t);
    check("c_sw_lat", 16'(t), 16'(5));
    wait_retire("c_lw", t);
    check("c_lw_lat", 16'(t), 16'(6));
    wait_halt("c_halt");
    check_reg("c_r2", 2'd2, 8'h5A);
    check("c_pc", 16'(pc), 16'(3));
    run_mode = 1'b0;

    // ---------------- branches, wrap, deferred start ----------------
    apply_reset();
    load(4'd0, enc_i(T_J, 2'd0, 2'd0, 8'd15));
    load(4'd15, enc_i(T_BEQ, 2'd0, 2'd0, 8'd1));
    load(4'd1, enc_i(T_BNE, 2'd0, 2'd0, 8'd5));
    load(4'd2, I_NOP);
    prog_we   = 1'b1;
    prog_addr = 4'd3;
    prog_data = I_HALT;
    step      = 1'b1;
    tick();
    prog_we = 1'b0;
    step    = 1'b0;
    tick(); tick();
    check("d_step_dropped", 16'(busy), 16'(0));
    check("d_pc_held", 16'(pc), 16'(0));
    step_instr("d_j", 4'd15, 8'h00, 3);
    step_instr("d_beq_wrap", 4'd1, 8'h00, 3);
    step_instr("d_bne_nt", 4'd2, 8'h00, 3);
    step_instr("d_nop", 4'd3, 8'h00, 3);
    pulse_step();
    wait_halt("d_halt");
    check("d_pc", 16'(pc), 16'(3));

    // ---------------- reset abort and busy write protection ----------------
    apply_reset();
    load(4'd0, enc_i(T_LI, 2'd0, 2'd1, 8'd1));
    load(4'd1, enc_i(T_LI, 2'd0, 2'd2, 8'd2));
    load(4'd2, enc_r(T_ADD, 2'd1, 2'd2, 2'd3));
    load(4'd3, I_HALT);
    step_instr("e_li1", 4'd1, 8'd1, 4);
    step_instr("e_li2", 4'd2, 8'd2, 4);
    pulse_step();
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = I_HALT;
    tick();
    tick();
    prog_we = 1'b0;
    check("e_busy_exec", 16'(busy), 16'(1));
    #2 rst_general = 1'b0;
    #1;
    check("e_rst_pc", 16'(pc), 16'(0));
    check("e_rst_busy", 16'(busy), 16'(0));
    check("e_rst_result", 16'(result), 16'(0));
    check_reg("e_rst_r3", 2'd3, 8'h00);
    check_reg("e_rst_r1", 2'd1, 8'h00);
    tick();
    rst_general = 1'b1;
    tick();
    step_instr("e_imem_kept", 4'd1, 8'd1, 4);
    check_reg("e_r1", 2'd1, 8'd1);
    check_reg("e_r3_after", 2'd3, 8'h00);

    check("sb_empty", 16'(exp_q.size()), 16'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
